// File: rtl/pio_pkg.sv
// Shared parameters for the PIO program-counter bank.
// Defaults match the reference core: four lanes, 32-entry memory, 5-bit delay field.
package pio_pkg;

  localparam int PIO_NUM_SM   = 4;
  localparam int PIO_ADDR_W   = 5;
  localparam int PIO_DELAY_W  = 5;
  localparam int PIO_RESET_PC = 0;

endpackage

// File: rtl/pio_pc_lane.sv
// One state-machine lane: program counter, wrap window, jump, stall and
// post-instruction delay countdown, resolved in a fixed priority order.
module pio_pc_lane
  import pio_pkg::*;
#(
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int DELAY_W = PIO_DELAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sm_en,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  wrap_top,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               stall,
  input  logic [DELAY_W-1:0] delay_val,
  output logic [ADDR_W-1:0]  pc,
  output logic               exec_valid,
  output logic               in_delay
);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [DELAY_W-1:0] dcnt_q;
  logic [DELAY_W-1:0] dcnt_d;

  assign exec_valid = sm_en & ~restart & (dcnt_q == '0);
  assign in_delay   = (dcnt_q != '0);
  assign pc         = pc_q;

  // Restart beats everything, including a disabled lane; a running delay
  // masks jump/stall/delay_val entirely until it has drained.
  always_comb begin
    pc_d   = pc_q;
    dcnt_d = dcnt_q;
    if (restart) begin
      pc_d   = wrap_top;
      dcnt_d = '0;
    end else if (sm_en) begin
      if (dcnt_q != '0) begin
        dcnt_d = dcnt_q - DELAY_W'(1);
      end else if (!stall) begin
        dcnt_d = delay_val;
        if (jump_en) begin
          pc_d = jump_addr;
        end else if (pc_q == wrap_bottom) begin
          pc_d = wrap_top;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= ADDR_W'(PIO_RESET_PC);
      dcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/pio_pc_bank.sv
// Bank of independent program counters, one per PIO state machine.
// Only slices the flattened per-lane buses; all behaviour lives in pio_pc_lane.
module pio_pc_bank
  import pio_pkg::*;
#(
  parameter int NUM_SM  = PIO_NUM_SM,
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int DELAY_W = PIO_DELAY_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SM-1:0]         sm_en,
  input  logic [NUM_SM-1:0]         restart,
  input  logic [NUM_SM*ADDR_W-1:0]  wrap_top,
  input  logic [NUM_SM*ADDR_W-1:0]  wrap_bottom,
  input  logic [NUM_SM-1:0]         jump_en,
  input  logic [NUM_SM*ADDR_W-1:0]  jump_addr,
  input  logic [NUM_SM-1:0]         stall,
  input  logic [NUM_SM*DELAY_W-1:0] delay_val,
  output logic [NUM_SM*ADDR_W-1:0]  pc,
  output logic [NUM_SM-1:0]         exec_valid,
  output logic [NUM_SM-1:0]         in_delay
);

  for (genvar g = 0; g < NUM_SM; g++) begin : g_lane
    pio_pc_lane #(
      .ADDR_W  (ADDR_W),
      .DELAY_W (DELAY_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .sm_en       (sm_en[g]),
      .restart     (restart[g]),
      .wrap_top    (wrap_top[g*ADDR_W +: ADDR_W]),
      .wrap_bottom (wrap_bottom[g*ADDR_W +: ADDR_W]),
      .jump_en     (jump_en[g]),
      .jump_addr   (jump_addr[g*ADDR_W +: ADDR_W]),
      .stall       (stall[g]),
      .delay_val   (delay_val[g*DELAY_W +: DELAY_W]),
      .pc          (pc[g*ADDR_W +: ADDR_W]),
      .exec_valid  (exec_valid[g]),
      .in_delay    (in_delay[g])
    );
  end

endmodule

// File: tb/tb_pio_pc_bank.sv
// Self-checking bench for pio_pc_bank: directed scenarios plus randomized
// traffic compared against an integer reference model of every lane.
module tb_pio_pc_bank;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    sm_en, restart, jump_en, stall;
  logic [N*AW-1:0] wrap_top, wrap_bottom, jump_addr;
  logic [N*DW-1:0] delay_val;
  logic [N*AW-1:0] pc;
  logic [N-1:0]    exec_valid, in_delay;

  int m_pc[N];
  int m_dc[N];
  int checks = 0;
  int errors = 0;

  pio_pc_bank #(.NUM_SM(N), .ADDR_W(AW), .DELAY_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sm_en       (sm_en),
    .restart     (restart),
    .wrap_top    (wrap_top),
    .wrap_bottom (wrap_bottom),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .stall       (stall),
    .delay_val   (delay_val),
    .pc          (pc),
    .exec_valid  (exec_valid),
    .in_delay    (in_delay)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] dut_pc(int i);
    return pc[i*AW +: AW];
  endfunction

  task automatic clear_inputs();
    sm_en       = '1;
    restart     = '0;
    jump_en     = '0;
    stall       = '0;
    wrap_top    = '0;
    wrap_bottom = '1;
    jump_addr   = '0;
    delay_val   = '0;
  endtask

  // Reference model: program counter as a plain integer, delay as a count of cycles left.
  task automatic tick();
    int npc[N];
    int ndc[N];
    for (int i = 0; i < N; i++) begin
      npc[i] = m_pc[i];
      ndc[i] = m_dc[i];
      if (restart[i]) begin
        npc[i] = int'(wrap_top[i*AW +: AW]);
        ndc[i] = 0;
      end else if (!sm_en[i]) begin
      end else if (m_dc[i] > 0) begin
        ndc[i] = m_dc[i] - 1;
      end else if (!stall[i]) begin
        ndc[i] = int'(delay_val[i*DW +: DW]);
        if (jump_en[i])
          npc[i] = int'(jump_addr[i*AW +: AW]);
        else if (m_pc[i] == int'(wrap_bottom[i*AW +: AW]))
          npc[i] = int'(wrap_top[i*AW +: AW]);
        else
          npc[i] = (m_pc[i] + 1) % (1 << AW);
      end
    end
    @(posedge clk);
    if (rst_n) begin
      m_pc = npc;
      m_dc = ndc;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    delay_val = {N{5'd10}};
    repeat (3) tick();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pc[i] = 0;
      m_dc[i] = 0;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_pc(i) !== AW'(0)) begin
        errors++;
        $display("[TB] FAIL reset_pc lane %0d: got %0d expected 0", i, dut_pc(i));
      end
    end
    checks++;
    if (in_delay !== 4'b0000 || exec_valid !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_flags: in_delay=%b exec_valid=%b expected 0000/1111", in_delay, exec_valid);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_restart();
    clear_inputs();
    sm_en   = 4'b0010;
    restart = 4'b0010;
    wrap_top[1*AW +: AW] = 5'd7;
    #1;
    checks++;
    if (exec_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL restart_exec_valid: got %b expected 0000", exec_valid);
    end
    tick();
    restart = '0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_pc(i) !== AW'((i == 1) ? 7 : 0)) begin
        errors++;
        $display("[TB] FAIL restart_pc lane %0d: got %0d expected %0d", i, dut_pc(i), (i == 1) ? 7 : 0);
      end
    end
  endtask

  task automatic test_wrap();
    int seq[6] = '{2, 3, 4, 5, 2, 3};
    clear_inputs();
    sm_en = 4'b0001;
    wrap_top[0 +: AW]    = 5'd2;
    wrap_bottom[0 +: AW] = 5'd5;
    restart = 4'b0001;
    tick();
    restart = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (dut_pc(0) !== AW'(seq[k])) begin
        errors++;
        $display("[TB] FAIL wrap_seq step %0d: got %0d expected %0d", k, dut_pc(0), seq[k]);
      end
      tick();
    end
    wrap_top[0 +: AW] = 5'd31;
    restart = 4'b0001;
    tick();
    restart = '0;
    wrap_bottom[0 +: AW] = 5'd4;
    tick();
    #1;
    checks++;
    if (dut_pc(0) !== AW'(0)) begin
      errors++;
      $display("[TB] FAIL wrap_rollover: got %0d expected 0", dut_pc(0));
    end
  endtask

  task automatic test_jump_vs_wrap();
    clear_inputs();
    sm_en = 4'b0001;
    wrap_top[0 +: AW] = 5'd5;
    restart = 4'b0001;
    tick();
    restart = '0;
    wrap_top[0 +: AW]    = 5'd2;
    wrap_bottom[0 +: AW] = 5'd5;
    jump_en   = 4'b0001;
    jump_addr[0 +: AW] = 5'd9;
    tick();
    jump_en = '0;
    #1;
    checks++;
    if (dut_pc(0) !== AW'(9)) begin
      errors++;
      $display("[TB] FAIL jump_over_wrap: got %0d expected 9", dut_pc(0));
    end
    wrap_bottom[0 +: AW] = 5'd9;
    tick();
    #1;
    checks++;
    if (dut_pc(0) !== AW'(2)) begin
      errors++;
      $display("[TB] FAIL wrap_after_jump: got %0d expected 2", dut_pc(0));
    end
  endtask

  task automatic test_delay();
    clear_inputs();
    sm_en = 4'b0001;
    wrap_top[0 +: AW] = 5'd3;
    restart = 4'b0001;
    tick();
    restart = '0;
    delay_val[0 +: DW] = 5'd3;
    tick();
    delay_val = '0;
    jump_en   = 4'b0001;
    jump_addr[0 +: AW] = 5'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (dut_pc(0) !== AW'(4) || exec_valid[0] !== 1'b0 || in_delay[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL delay_hold cycle %0d: pc=%0d ev=%b id=%b expected 4/0/1", k, dut_pc(0), exec_valid[0], in_delay[0]);
      end
      tick();
    end
    jump_en = '0;
    #1;
    checks++;
    if (dut_pc(0) !== AW'(4) || exec_valid[0] !== 1'b1 || in_delay[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL delay_resume: pc=%0d ev=%b id=%b expected 4/1/0", dut_pc(0), exec_valid[0], in_delay[0]);
    end
  endtask

  task automatic test_stall_then_delay();
    clear_inputs();
    sm_en = 4'b0001;
    wrap_top[0 +: AW] = 5'd6;
    restart = 4'b0001;
    tick();
    restart = '0;
    stall   = 4'b0001;
    delay_val[0 +: DW] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (dut_pc(0) !== AW'(6) || in_delay[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d: pc=%0d id=%b expected 6/0", k, dut_pc(0), in_delay[0]);
      end
      tick();
    end
    stall = '0;
    tick();
    delay_val = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (dut_pc(0) !== AW'(7) || exec_valid[0] !== 1'b0 || in_delay[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_delay cycle %0d: pc=%0d ev=%b id=%b expected 7/0/1", k, dut_pc(0), exec_valid[0], in_delay[0]);
      end
      tick();
    end
    #1;
    checks++;
    if (exec_valid[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_delay_end: ev=%b expected 1", exec_valid[0]);
    end
  endtask

  task automatic test_lane_enable();
    int frozen_pc;
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      wrap_top[i*AW +: AW]    = AW'(1 + 8*i);
      wrap_bottom[i*AW +: AW] = AW'(4 + 8*i);
    end
    restart = '1;
    tick();
    restart = '0;
    delay_val[2*DW +: DW] = 5'd5;
    tick();
    delay_val = '0;
    tick();
    sm_en[2]  = 1'b0;
    frozen_pc = m_pc[2];
    for (int k = 0; k < 10; k++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_pc(i) !== AW'(m_pc[i])) begin
          errors++;
          $display("[TB] FAIL enable_pc lane %0d cycle %0d: got %0d expected %0d", i, k, dut_pc(i), m_pc[i]);
        end
      end
      checks++;
      if (dut_pc(2) !== AW'(frozen_pc) || in_delay[2] !== 1'b1 || exec_valid[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL frozen_lane cycle %0d: pc=%0d id=%b ev=%b expected %0d/1/0", k, dut_pc(2), in_delay[2], exec_valid[2], frozen_pc);
      end
      tick();
    end
    sm_en[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_delay[2] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL resume_countdown cycle %0d: id=%b expected 1", k, in_delay[2]);
      end
      tick();
    end
    #1;
    checks++;
    if (in_delay[2] !== 1'b0 || exec_valid[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_end: id=%b ev=%b expected 0/1", in_delay[2], exec_valid[2]);
    end
    sm_en[2] = 1'b0;
    wrap_top[2*AW +: AW] = 5'd13;
    restart[2] = 1'b1;
    tick();
    restart = '0;
    #1;
    checks++;
    if (dut_pc(2) !== AW'(13)) begin
      errors++;
      $display("[TB] FAIL restart_disabled: got %0d expected 13", dut_pc(2));
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        sm_en[i]   = ($urandom_range(0, 9) != 0);
        restart[i] = ($urandom_range(0, 29) == 0);
        jump_en[i] = ($urandom_range(0, 9) == 0);
        stall[i]   = ($urandom_range(0, 3) == 0);
        wrap_top[i*AW +: AW]    = AW'($urandom_range(0, 31));
        wrap_bottom[i*AW +: AW] = AW'($urandom_range(0, 31));
        jump_addr[i*AW +: AW]   = AW'($urandom_range(0, 31));
        delay_val[i*DW +: DW]   = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(1, 4)) : DW'(0);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_pc(i) !== AW'(m_pc[i]) ||
            exec_valid[i] !== (sm_en[i] && !restart[i] && m_dc[i] == 0) ||
            in_delay[i] !== (m_dc[i] != 0)) begin
          errors++;
          $display("[TB] FAIL random cycle %0d lane %0d: pc=%0d ev=%b id=%b expected pc=%0d dcnt=%0d",
                   c, i, dut_pc(i), exec_valid[i], in_delay[i], m_pc[i], m_dc[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pc[i] = 0;
      m_dc[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_restart();
    test_wrap();
    test_jump_vs_wrap();
    test_delay();
    test_stall_then_delay();
    test_lane_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
